// File: rtl/uart_pkg.sv
// Shared constants for the uart byte-buffering stage: feeder FSM encodings,
// default FIFO depth and error-counter ceiling.
package uart_pkg;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_ARM  = 2'd1;
  localparam logic [1:0] F_BUSY = 2'd2;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;
  localparam logic [7:0]  ERRCNT_MAX         = 8'd255;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and a separate level counter.
// FULL_PUSH_POP lets a push land on a full FIFO when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter bit          FULL_PUSH_POP = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || (FULL_PUSH_POP && pop_ok));

  // Storage is not reset; the head reads as zero while empty.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo.sv
// Byte buffering between CPU and uart core: TX queue with frame feeder, RX queue with
// overflow status. Define UART_FIFO_ERRCNT_EN to enable the receive-error counter.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_wr,
  input  logic [7:0]          tx_data,
  output logic                tx_full,
  output logic [DEPTH_LOG2:0] tx_level,
  input  logic                rx_rd,
  output logic [7:0]          rx_data,
  output logic                rx_empty,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic                rx_overflow,
  input  logic                ovf_clr,
  output logic [7:0]          err_count,
  output logic                uart_transmit,
  output logic [7:0]          uart_tx_byte,
  input  logic                uart_is_transmitting,
  input  logic                uart_received,
  input  logic [7:0]          uart_rx_byte,
  input  logic                uart_recv_error
);

  logic [7:0] tx_head;
  logic       tx_empty, tx_pop;
  logic       rx_full;
  logic [1:0] state_q, state_d;
  logic       transmit_q, transmit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       overflow_q, overflow_d;

  uart_sync_fifo #(
    .WIDTH        (8),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .FULL_PUSH_POP(1'b0)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_wr),
    .din  (tx_data),
    .pop  (tx_pop),
    .dout (tx_head),
    .full (tx_full),
    .empty(tx_empty),
    .level(tx_level)
  );

  // A received byte arriving on a full FIFO survives if the CPU pops in the same cycle.
  uart_sync_fifo #(
    .WIDTH        (8),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .FULL_PUSH_POP(1'b1)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (uart_received),
    .din  (uart_rx_byte),
    .pop  (rx_rd),
    .dout (rx_data),
    .full (rx_full),
    .empty(rx_empty),
    .level(rx_level)
  );

  always_comb begin
    state_d    = state_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_pop     = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (!tx_empty && !uart_is_transmitting) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          transmit_d = 1'b1;
          state_d    = F_ARM;
        end
      end
      F_ARM:   if (uart_is_transmitting)  state_d = F_BUSY;
      F_BUSY:  if (!uart_is_transmitting) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (uart_received && rx_full && !rx_rd) overflow_d = 1'b1;
    else if (ovf_clr)                       overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign rx_overflow   = overflow_q;

`ifdef UART_FIFO_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (ovf_clr)                                  err_d = '0;
    else if (uart_recv_error && err_q != ERRCNT_MAX) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo with a simple busy-for-40-cycles uart model.
module tb_uart_fifo;

`ifdef UART_FIFO_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_full;
  logic [4:0] tx_level;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic [4:0] rx_level;
  logic       rx_overflow;
  logic       ovf_clr = 1'b0;
  logic [7:0] err_count;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting = 1'b0;
  logic       uart_received = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic       uart_recv_error = 1'b0;

  int tests = 0;
  int fails = 0;

  logic       hold = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] tx_log[$];

  uart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tx_wr               (tx_wr),
    .tx_data             (tx_data),
    .tx_full             (tx_full),
    .tx_level            (tx_level),
    .rx_rd               (rx_rd),
    .rx_data             (rx_data),
    .rx_empty            (rx_empty),
    .rx_level            (rx_level),
    .rx_overflow         (rx_overflow),
    .ovf_clr             (ovf_clr),
    .err_count           (err_count),
    .uart_transmit       (uart_transmit),
    .uart_tx_byte        (uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received       (uart_received),
    .uart_rx_byte        (uart_rx_byte),
    .uart_recv_error     (uart_recv_error)
  );

  always #5 clk = ~clk;

  // Uart model: each negedge-sampled transmit cycle logs one byte and starts 40 busy cycles.
  always @(negedge clk) begin
    if (uart_transmit) begin
      tx_log.push_back(uart_tx_byte);
      busy_cnt = 40;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    uart_is_transmitting = hold || (busy_cnt > 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    tx_wr = 1'b1;
    tx_data = b;
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
  endtask

  task automatic rx_cycle(input logic rcv, input logic [7:0] b, input logic rd, input logic clr);
    @(negedge clk);
    uart_received = rcv;
    uart_rx_byte = b;
    rx_rd = rd;
    ovf_clr = clr;
    @(posedge clk);
    #1;
    uart_received = 1'b0;
    rx_rd = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (tx_log.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    tests++;
    if (tx_log.size() < n) begin
      fails++;
      $display("FAIL %s: got %0d transmit pulses, expected %0d", name, tx_log.size(), n);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if (tx_full !== 1'b0 || tx_level !== 5'd0 || rx_empty !== 1'b1 || rx_level !== 5'd0 ||
        rx_data !== 8'h00 || rx_overflow !== 1'b0 || err_count !== 8'h00 ||
        uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00) begin
      fails++;
      $display("FAIL %s: full=%b txl=%0d empty=%b rxl=%0d rxd=%h ovf=%b err=%0d tx=%b txb=%h, expected 0 0 1 0 00 0 0 0 00",
               name, tx_full, tx_level, rx_empty, rx_level, rx_data, rx_overflow, err_count,
               uart_transmit, uart_tx_byte);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_tx_basic;
    tx_log.delete();
    tx_write(8'h41);
    tests++;
    if (uart_transmit !== 1'b0) begin
      fails++;
      $display("FAIL latency_n1: uart_transmit=%b expected 0", uart_transmit);
    end
    @(posedge clk);
    #1;
    tests++;
    if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h41) begin
      fails++;
      $display("FAIL latency_n2: transmit=%b byte=%h expected 1 41", uart_transmit, uart_tx_byte);
    end
    tx_write(8'h42);
    tests++;
    if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h41) begin
      fails++;
      $display("FAIL pulse_width: transmit=%b byte=%h expected 0 41", uart_transmit, uart_tx_byte);
    end
    tx_write(8'h43);
    wait_log(3, 300, "tx_three_pulses");
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= tx_log.size() || tx_log[i] !== 8'h41 + i[7:0]) begin
        fails++;
        $display("FAIL tx_order[%0d]: got %h expected %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 8'hxx, 8'h41 + i[7:0]);
      end
    end
    repeat (50) @(posedge clk);
    #1;
    tests++;
    if (tx_level !== 5'd0 || tx_log.size() != 3) begin
      fails++;
      $display("FAIL tx_drained: level=%0d pulses=%0d expected 0 3", tx_level, tx_log.size());
    end
  endtask

  task automatic test_tx_full;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    tx_log.delete();
    for (int i = 0; i < 17; i++) begin
      tx_write(i[7:0]);
      if (i == 15) begin
        tests++;
        if (tx_full !== 1'b1 || tx_level !== 5'd16) begin
          fails++;
          $display("FAIL tx_full_16: full=%b level=%0d expected 1 16", tx_full, tx_level);
        end
      end
    end
    tests++;
    if (tx_full !== 1'b1 || tx_level !== 5'd16 || tx_log.size() != 0) begin
      fails++;
      $display("FAIL tx_full_17: full=%b level=%0d pulses=%0d expected 1 16 0",
               tx_full, tx_level, tx_log.size());
    end
    @(negedge clk);
    hold = 1'b0;
    wait_log(16, 1200, "tx_full_drain");
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (i >= tx_log.size() || tx_log[i] !== i[7:0]) begin
        fails++;
        $display("FAIL tx_full_order[%0d]: got %h expected %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 8'hxx, i[7:0]);
      end
    end
    repeat (60) @(posedge clk);
    #1;
    tests++;
    if (tx_log.size() != 16 || tx_level !== 5'd0) begin
      fails++;
      $display("FAIL tx_byte_dropped: pulses=%0d level=%0d expected 16 0", tx_log.size(), tx_level);
    end
  endtask

  task automatic test_rx_overflow;
    for (int i = 0; i < 17; i++) rx_cycle(1'b1, 8'h80 + i[7:0], 1'b0, 1'b0);
    tests++;
    if (rx_level !== 5'd16 || rx_overflow !== 1'b1 || rx_data !== 8'h80 || rx_empty !== 1'b0) begin
      fails++;
      $display("FAIL rx_overflow: level=%0d ovf=%b head=%h empty=%b expected 16 1 80 0",
               rx_level, rx_overflow, rx_data, rx_empty);
    end
    rx_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    tests++;
    if (rx_overflow !== 1'b1 || rx_data !== 8'h80) begin
      fails++;
      $display("FAIL ovf_set_wins: ovf=%b head=%h expected 1 80", rx_overflow, rx_data);
    end
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (rx_overflow !== 1'b0 || rx_level !== 5'd16) begin
      fails++;
      $display("FAIL ovf_clr: ovf=%b level=%0d expected 0 16", rx_overflow, rx_level);
    end
  endtask

  task automatic test_rx_full_push_pop;
    logic [7:0] exp;
    rx_cycle(1'b1, 8'h91, 1'b1, 1'b0);
    tests++;
    if (rx_overflow !== 1'b0 || rx_data !== 8'h81 || rx_level !== 5'd16) begin
      fails++;
      $display("FAIL rx_full_push_pop: ovf=%b head=%h level=%0d expected 0 81 16",
               rx_overflow, rx_data, rx_level);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h91 : 8'h81 + i[7:0];
      tests++;
      if (rx_data !== exp) begin
        fails++;
        $display("FAIL rx_drain[%0d]: head=%h expected %h", i, rx_data, exp);
      end
      rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    tests++;
    if (rx_empty !== 1'b1 || rx_level !== 5'd0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL rx_empty_after_drain: empty=%b level=%0d head=%h expected 1 0 00",
               rx_empty, rx_level, rx_data);
    end
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin
      fails++;
      $display("FAIL rx_pop_empty: level=%0d empty=%b expected 0 1", rx_level, rx_empty);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) tx_write(8'hA0 + i[7:0]);
    rx_cycle(1'b1, 8'h33, 1'b0, 1'b0);
    tests++;
    if (tx_level !== 5'd5 || rx_data !== 8'h33) begin
      fails++;
      $display("FAIL pre_reset: tx_level=%0d rx_head=%h expected 5 33", tx_level, rx_data);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    tx_log.delete();
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (tx_log.size() != 0 || tx_level !== 5'd0) begin
      fails++;
      $display("FAIL reset_discard: pulses=%0d level=%0d expected 0 0", tx_log.size(), tx_level);
    end
    tx_write(8'h55);
    wait_log(1, 20, "post_reset_tx");
    tests++;
    if (tx_log.size() < 1 || tx_log[0] !== 8'h55) begin
      fails++;
      $display("FAIL post_reset_byte: got %h expected 55", (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
    end
    repeat (50) @(posedge clk);
  endtask

  task automatic test_err_count;
    logic [7:0] exp10, exp300;
    exp10  = ERRCNT_ON ? 8'd10 : 8'd0;
    exp300 = ERRCNT_ON ? 8'd255 : 8'd0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      uart_recv_error = 1'b1;
      @(negedge clk);
      uart_recv_error = 1'b0;
      if (i == 9) begin
        tests++;
        if (err_count !== exp10) begin
          fails++;
          $display("FAIL err_count_10: got %0d expected %0d", err_count, exp10);
        end
      end
    end
    tests++;
    if (err_count !== exp300) begin
      fails++;
      $display("FAIL err_count_sat: got %0d expected %0d", err_count, exp300);
    end
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (err_count !== 8'd0) begin
      fails++;
      $display("FAIL err_count_clr: got %0d expected 0", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_overflow();
    test_rx_full_push_pop();
    test_async_reset();
    test_err_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
